// File: rtl/mul_pkg.sv
// Shared definitions for the Booth multiplier sequencer slice.
package mul_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEPS = DEF_WIDTH / 2;
  localparam int IDX_W     = $clog2(DEF_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STEP,
    S_CAPTURE,
    S_DONE
  } state_t;

endpackage

// File: rtl/mul_hilo_sequencer_hilo_regs.sv
// Architectural HI/LO pair: multiply capture has priority over bus writes.
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cap_en,
  input  logic             bus_en,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] cap_hi,
  input  logic [WIDTH-1:0] cap_lo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  // Capture wins; bus writes land only while the sequencer permits them.
  always_ff @(posedge clk) begin
    if (clr) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (cap_en) begin
      hi_out <= cap_hi;
      lo_out <= cap_lo;
    end else if (bus_en) begin
      if (hi_we) hi_out <= hi_in;
      if (lo_we) lo_out <= lo_in;
    end
  end

endmodule

// File: rtl/mul_hilo_sequencer.sv
// Control and writeback sequencer for the radix-4 Booth multiplier datapath.
module mul_hilo_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPS = WIDTH / 2
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  input  logic [WIDTH-1:0]         hi_in,
  input  logic [WIDTH-1:0]         lo_in,
  input  logic                     hi_we,
  input  logic                     lo_we,
  input  logic [WIDTH-1:0]         mul_hi,
  input  logic [WIDTH-1:0]         mul_lo,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_clear,
  output logic                     mul_step,
  output logic [$clog2(WIDTH)-1:0] mul_idx,
  output logic [WIDTH-1:0]         hi_out,
  output logic [WIDTH-1:0]         lo_out,
  output logic                     busy,
  output logic                     stall,
  output logic                     done
);

  localparam int CW = $clog2(WIDTH) - 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  state_t        state, state_n;
  logic [CW-1:0] step_cnt;
  logic          accept;
  logic          last_step;
  logic          capture;
  logic          bus_en;

  // Bit-pair index is the step count doubled, so it is held whenever the count is.
  assign mul_idx   = {step_cnt, 1'b0};
  assign last_step = (step_cnt == LAST_STEP);

  // State, step counter and operand latches.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      step_cnt <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        mul_a    <= op_a;
        mul_b    <= op_b;
        step_cnt <= '0;
      end else if (state == S_STEP && !last_step) begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    mul_clear = 1'b0;
    mul_step  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    capture   = 1'b0;
    bus_en    = 1'b0;
    case (state)
      S_IDLE: begin
        bus_en = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_n = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy      = 1'b1;
        mul_clear = 1'b1;
        state_n   = S_STEP;
      end
      S_STEP: begin
        busy     = 1'b1;
        mul_step = 1'b1;
        if (last_step) state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy    = 1'b1;
        capture = 1'b1;
        state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        bus_en  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    stall = busy | accept;
  end

  hilo_regs #(.WIDTH(WIDTH)) u_hilo (
    .clk    (clk),
    .clr    (clr),
    .cap_en (capture),
    .bus_en (bus_en),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .hi_in  (hi_in),
    .lo_in  (lo_in),
    .cap_hi (mul_hi),
    .cap_lo (mul_lo),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

endmodule
